// File: rtl/axis_to_axi4_wr_burst_split.sv
// Command-driven AXI-Stream to AXI4 write bridge. It splits each command into INCR bursts
// that are bounded by MAX_BURST and by 4 KB pages, and it limits the number of bursts in flight.
module axis_to_axi4_wr_burst_split #(
    parameter int DSIZE           = 64,
    parameter int ASIZE           = 32,
    parameter int IDSIZE          = 4,
    parameter int LSIZE           = 8,
    parameter int MAX_BURST       = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ASIZE-1:0]     cmd_addr,
    input  logic [31:0]          cmd_beats,
    input  logic                 axis_tvalid,
    output logic                 axis_tready,
    input  logic [DSIZE-1:0]     axis_tdata,
    input  logic [DSIZE/8-1:0]   axis_tkeep,
    input  logic                 axis_tlast,
    output logic [IDSIZE-1:0]    axi_awid,
    output logic [ASIZE-1:0]     axi_awaddr,
    output logic [LSIZE-1:0]     axi_awlen,
    output logic [2:0]           axi_awsize,
    output logic [1:0]           axi_awburst,
    output logic                 axi_awvalid,
    input  logic                 axi_awready,
    output logic [DSIZE-1:0]     axi_wdata,
    output logic [DSIZE/8-1:0]   axi_wstrb,
    output logic                 axi_wlast,
    output logic                 axi_wvalid,
    input  logic                 axi_wready,
    input  logic [IDSIZE-1:0]    axi_bid,
    input  logic [1:0]           axi_bresp,
    input  logic                 axi_bvalid,
    output logic                 axi_bready,
    output logic                 done,
    output logic                 err_resp,
    output logic                 err_len
);
    localparam int BYTES  = DSIZE / 8;
    localparam int BSHIFT = $clog2(BYTES);
    localparam int OW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int BLW    = LSIZE + 1;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ASIZE-1:0]  addr_q, addr_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [BLW-1:0]    blen_q, blen_d;
    logic [LSIZE-1:0]  beat_q, beat_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic [IDSIZE-1:0] awid_q, awid_d;
    logic [ASIZE-1:0]  awaddr_q, awaddr_d;
    logic [LSIZE-1:0]  awlen_q, awlen_d;
    logic              awvalid_q, awvalid_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              bready_q;
    logic              done_q, done_d;
    logic              err_resp_q, err_resp_d;
    logic              err_len_q, err_len_d;

    logic              in_w, aw_hs, w_hs, b_hs, wlast_c, final_beat;
    logic [12:0]       to4k;
    logic [31:0]       blen_calc;
    logic              unused_bid;

    assign unused_bid = ^axi_bid;

    assign in_w       = (state_q == S_W);
    assign aw_hs      = awvalid_q & axi_awready;
    assign w_hs       = axi_wvalid & axi_wready;
    assign b_hs       = axi_bvalid & bready_q;
    assign wlast_c    = in_w && ({1'b0, beat_q} == (blen_q - BLW'(1)));
    assign final_beat = wlast_c && (remaining_q == 32'(blen_q));

    // Beats left in the current 4 KB page; only the page offset matters.
    assign to4k = (13'd4096 - {1'b0, addr_q[11:0]}) >> BSHIFT;

    always_comb begin
        blen_calc = remaining_q;
        if (blen_calc > 32'(MAX_BURST)) blen_calc = 32'(MAX_BURST);
        if (blen_calc > 32'(to4k))      blen_calc = 32'(to4k);
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        blen_d        = blen_q;
        beat_d        = beat_q;
        awid_d        = awid_q;
        awaddr_d      = awaddr_q;
        awlen_d       = awlen_q;
        awvalid_d     = awvalid_q;
        done_d        = 1'b0;
        err_resp_d    = err_resp_q;
        err_len_d     = err_len_q;
        outstanding_d = outstanding_q;

        case ({aw_hs, b_hs})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    remaining_d = cmd_beats;
                    err_resp_d  = 1'b0;
                    err_len_d   = 1'b0;
                    state_d     = (cmd_beats == 32'd0) ? S_DRAIN : S_CALC;
                end
            end
            S_CALC: begin
                if (outstanding_q != OW'(MAX_OUTSTANDING)) begin
                    awaddr_d  = addr_q;
                    awlen_d   = LSIZE'(blen_calc - 32'd1);
                    blen_d    = BLW'(blen_calc);
                    awvalid_d = 1'b1;
                    state_d   = S_AW;
                end
            end
            S_AW: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    awid_d    = awid_q + IDSIZE'(1);
                    beat_d    = '0;
                    state_d   = S_W;
                end
            end
            S_W: begin
                if (w_hs) begin
                    // tlast must coincide exactly with the command's final beat.
                    if (axis_tlast != final_beat) err_len_d = 1'b1;
                    if (wlast_c) begin
                        addr_d      = addr_q + (ASIZE'(blen_q) << BSHIFT);
                        remaining_d = remaining_q - 32'(blen_q);
                        beat_d      = '0;
                        state_d     = final_beat ? S_DRAIN : S_CALC;
                    end else begin
                        beat_d = beat_q + LSIZE'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (outstanding_d == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (b_hs && (axi_bresp != 2'b00)) err_resp_d = 1'b1;
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            blen_q        <= '0;
            beat_q        <= '0;
            outstanding_q <= '0;
            awid_q        <= '0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            awvalid_q     <= 1'b0;
            cmd_ready_q   <= 1'b0;
            bready_q      <= 1'b0;
            done_q        <= 1'b0;
            err_resp_q    <= 1'b0;
            err_len_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            blen_q        <= blen_d;
            beat_q        <= beat_d;
            outstanding_q <= outstanding_d;
            awid_q        <= awid_d;
            awaddr_q      <= awaddr_d;
            awlen_q       <= awlen_d;
            awvalid_q     <= awvalid_d;
            cmd_ready_q   <= cmd_ready_d;
            bready_q      <= 1'b1;
            done_q        <= done_d;
            err_resp_q    <= err_resp_d;
            err_len_q     <= err_len_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign axi_awid    = awid_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awlen   = awlen_q;
    assign axi_awsize  = 3'(BSHIFT);
    assign axi_awburst = 2'b01;
    assign axi_awvalid = awvalid_q;
    assign axi_bready  = bready_q;
    assign done        = done_q;
    assign err_resp    = err_resp_q;
    assign err_len     = err_len_q;

    // The W channel is a direct pass-through of the stream while a burst is open.
    assign axi_wvalid  = in_w & axis_tvalid;
    assign axis_tready = in_w & axi_wready;
    assign axi_wdata   = in_w ? axis_tdata : '0;
    assign axi_wstrb   = in_w ? axis_tkeep : '0;
    assign axi_wlast   = wlast_c;

endmodule

// File: doc/axis_to_axi4_wr_burst_split.md
Name: axis_to_axi4_wr_burst_split

Overview:
- Single-clock, command-driven successor of the AXIS→AXI4 write bridge.
- Takes a command (start address, total beat count) and an AXI-Stream payload.
- Splits the transfer into AXI4 INCR bursts bounded by MAX_BURST beats and by 4 KB address boundaries.
- Issues AW before W, forwards tkeep as wstrb, limits outstanding bursts, collects B responses, and reports done plus sticky errors. Sits between DMA/packet engines and the AXI interconnect.

Parameters:
- DSIZE, 64: data width in bits; power of 2, 8..1024. BYTES = DSIZE/8.
- ASIZE, 32: address width.
- IDSIZE, 4: AXI ID width.
- LSIZE, 8: awlen width.
- MAX_BURST, 256: maximum beats per burst; ≤ 2**LSIZE.
- MAX_OUTSTANDING, 4: maximum AW-accepted bursts awaiting B; ≥ 1.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_addr  in  ASIZE  start address; BYTES-aligned
- cmd_beats  in  32  total beats
- axis_tvalid  in  1  stream valid
- axis_tready  out  1  stream ready
- axis_tdata  in  DSIZE  stream data
- axis_tkeep  in  BYTES  stream byte enables
- axis_tlast  in  1  stream last
- axi_awid  out  IDSIZE  burst ID
- axi_awaddr  out  ASIZE  burst address
- axi_awlen  out  LSIZE  burst length minus 1
- axi_awsize  out  3  log2(BYTES)
- axi_awburst  out  2  burst type
- axi_awvalid  out  1  AW valid
- axi_awready  in  1  AW ready
- axi_wdata  out  DSIZE  write data
- axi_wstrb  out  BYTES  write strobes
- axi_wlast  out  1  last beat of burst
- axi_wvalid  out  1  W valid
- axi_wready  in  1  W ready
- axi_bid  in  IDSIZE  response ID; ignored
- axi_bresp  in  2  write response
- axi_bvalid  in  1  B valid
- axi_bready  out  1  B ready
- done  out  1  one-cycle pulse when a command completes
- err_resp  out  1  sticky: any bresp ≠ 0 during the command
- err_len  out  1  sticky: tlast position ≠ cmd_beats

Behaviour:
- Reset values: all outputs 0 except axi_awsize (constant) and axi_awburst (constant 2'b01). State = IDLE; awid, outstanding counter and both error flags cleared. Reset mid-burst abandons the transfer with no completion.
- States: IDLE → CALC → AW → W → (CALC if beats remain, else DRAIN) → IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd handshake: latch addr and remaining = cmd_beats, clear err_resp/err_len.
  - If cmd_beats == 0, go to DRAIN; otherwise go to CALC.
- CALC (1 cycle):
  - to4k = (4096 − addr[11:0]) / BYTES.
  - blen = min(remaining, MAX_BURST, to4k).
  - Register awaddr = addr and awlen = blen − 1.
  - If outstanding == MAX_OUTSTANDING, stay in CALC.
  - awvalid asserts 2 cycles after cmd accept when the path is unblocked.
- AW:
  - awvalid held with awaddr, awlen and awid stable until awready.
  - On handshake: outstanding++, awid++ (wraps modulo 2**IDSIZE), go to W.
- W:
  - Combinational pass-through: wvalid = axis_tvalid, axis_tready = wready, wdata = tdata, wstrb = tkeep (no inversion).
  - Beat counter; wlast = (beat == blen − 1).
  - On the last beat handshake: addr += blen*BYTES, remaining −= blen.
  - axis_tready = 0 and wvalid = 0 in every state other than W.
- tlast check, per beat:
  - tlast on a beat other than the final beat of the command → err_len.
  - No tlast on the final beat → err_len.
  - The stream is never resynced; exactly cmd_beats beats are consumed.
- B channel:
  - bready = 1 always. On a bvalid handshake: outstanding−−; bresp ≠ 0 → err_resp.
  - AW and B handshakes in the same cycle leave outstanding unchanged.
- DRAIN: wait until outstanding == 0, then pulse done for 1 cycle and return to IDLE. Error flags hold until the next command accept.
- Width rules: addr arithmetic is modulo 2**ASIZE; the 4 KB math uses addr[11:0] only; outstanding counter width is $clog2(MAX_OUTSTANDING+1).

Test Plan:
1. DSIZE=64, MAX_BURST=16; cmd addr 0x0, beats 16 → one AW (addr 0x0, len 15, size 3, burst 1); 16 W beats with wlast on beat 16; done 1 cycle after the single B handshake.
2. 4 KB cross: addr 0xFC0, beats 16 → AW 0xFC0 len 7, then AW 0x1000 len 7; awid 0 then 1.
3. Long transfer: MAX_BURST=256, addr 0x0, beats 600 → AWs 0x0/len 255, 0x800/len 255, 0x1000/len 87; 600 W beats total; tkeep 0x0F appears unchanged on wstrb.
4. Outstanding limit: MAX_OUTSTANDING=2, bvalid withheld, 3 bursts → third awvalid does not assert until the first B handshake; then proceeds.
5. Errors:
   - bresp=2'b10 on the second of 2 bursts → err_resp = 1, done still pulses.
   - tlast on beat 5 of 8 → err_len = 1, 8 beats still sent.
   - Both flags clear on the next cmd accept.
6. Reset mid-burst: deassert axi_aresetn after beat 3 of 16 → all outputs 0 asynchronously, cmd_ready = 1 after release, a fresh command completes normally with awid = 0.
